// File: rtl/ring_packet_injector_pkg.sv
// Shared packet layout for the ring: field offsets, port encodings and a packet builder.
package ring_pkg;

   localparam int PACKET_SIZE = 49;
   localparam int DEST_LSB    = 0;
   localparam int SRC_LSB     = 16;
   localparam int TS_LSB      = 32;
   localparam int VALID_BIT   = 48;

   typedef enum logic [1:0] {
      LOCAL = 2'b00,
      EAST  = 2'b01,
      WEST  = 2'b10
   } port_e;

   typedef struct packed {
      logic        valid;
      logic [15:0] ts;
      logic [15:0] src;
      logic [15:0] dest;
   } packet_t;

   function automatic logic [PACKET_SIZE-1:0] makePacket(
      input logic [15:0] ts,
      input logic [15:0] src,
      input logic [15:0] dest
   );
      logic [PACKET_SIZE-1:0] pkt;
      pkt                   = '0;
      pkt[VALID_BIT]        = 1'b1;
      pkt[TS_LSB   +: 16]   = ts;
      pkt[SRC_LSB  +: 16]   = src;
      pkt[DEST_LSB +: 16]   = dest;
      return pkt;
   endfunction

endpackage

// File: rtl/ring_packet_injector_if.sv
// Request/packet bundle between the local node and the injector; the slave side is the injector.
interface ring_packet_injector_if #(
   parameter int PACKET_SIZE = ring_pkg::PACKET_SIZE
);

   logic                   req_valid;
   logic                   req_ready;
   logic [15:0]            req_dest;
   logic                   pkt_valid;
   logic                   pkt_ready;
   logic [PACKET_SIZE-1:0] pkt_out;
   logic [15:0]            inj_count;
   logic [15:0]            drop_count;

   modport master (
      output req_valid, req_dest, pkt_ready,
      input  req_ready, pkt_valid, pkt_out, inj_count, drop_count
   );

   modport slave (
      input  req_valid, req_dest, pkt_ready,
      output req_ready, pkt_valid, pkt_out, inj_count, drop_count
   );

endinterface

// File: rtl/ring_packet_injector_fifo.sv
// Show-ahead synchronous FIFO; head reads as zero while empty so the output bus is clean.
module ring_sync_fifo #(
   parameter int WIDTH = 49,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic             o_full,
   output logic             o_empty,
   output logic [WIDTH-1:0] o_head
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wrPtr;
   logic [AW:0]      r_rdPtr;
   logic             w_doPush;
   logic             w_doPop;

   // Extra pointer MSB distinguishes full from empty when the index bits match.
   assign o_empty  = (r_wrPtr == r_rdPtr);
   assign o_full   = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
   assign w_doPush = i_push && !o_full;
   assign w_doPop  = i_pop && !o_empty;
   assign o_head   = o_empty ? '0 : r_mem[r_rdPtr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
      end else begin
         if (w_doPush) begin
            r_wrPtr <= r_wrPtr + 1'b1;
         end
         if (w_doPop) begin
            r_rdPtr <= r_rdPtr + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_doPush) begin
         r_mem[r_wrPtr[AW-1:0]] <= i_data;
      end
   end

endmodule

// File: rtl/ring_packet_injector.sv
// Local packet source for one ring router: stamps src id and timestamp, buffers packets, drops bad dests.
module ring_packet_injector #(
   parameter int ROUTER_ID   = 0,
   parameter int NUM_ROUTERS = 8,
   parameter int PACKET_SIZE = 49,
   parameter int FIFO_DEPTH  = 4
) (
   input logic                    clk,
   input logic                    rst_n,
   ring_packet_injector_if.slave  injBus
);

   import ring_pkg::*;

   localparam logic [16:0] LP_NUM_ROUTERS = 17'(NUM_ROUTERS);
   localparam logic [15:0] LP_SRC_ID      = 16'(ROUTER_ID);

   logic [15:0]            r_tsCounter;
   logic [15:0]            r_injCount;
   logic [15:0]            r_dropCount;
   logic                   w_full;
   logic                   w_empty;
   logic                   w_accept;
   logic                   w_legal;
   logic                   w_push;
   logic                   w_pop;
   logic [PACKET_SIZE-1:0] w_newPkt;
   logic [PACKET_SIZE-1:0] w_head;

   // No same-cycle bypass: a full FIFO refuses requests even while it is being popped.
   assign w_legal  = ({1'b0, injBus.req_dest} < LP_NUM_ROUTERS);
   assign w_accept = injBus.req_valid && !w_full;
   assign w_push   = w_accept && w_legal;
   assign w_pop    = injBus.pkt_ready && !w_empty;
   assign w_newPkt = makePacket(r_tsCounter, LP_SRC_ID, injBus.req_dest);

   ring_sync_fifo #(
      .WIDTH (PACKET_SIZE),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_data  (w_newPkt),
      .i_pop   (w_pop),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_head  (w_head)
   );

   assign injBus.req_ready  = !w_full;
   assign injBus.pkt_valid  = !w_empty;
   assign injBus.pkt_out    = w_head;
   assign injBus.inj_count  = r_injCount;
   assign injBus.drop_count = r_dropCount;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tsCounter <= '0;
         r_injCount  <= '0;
         r_dropCount <= '0;
      end else begin
         r_tsCounter <= r_tsCounter + 16'd1;
         if (w_pop && (r_injCount != 16'hFFFF)) begin
            r_injCount <= r_injCount + 16'd1;
         end
         if (w_accept && !w_legal && (r_dropCount != 16'hFFFF)) begin
            r_dropCount <= r_dropCount + 16'd1;
         end
      end
   end

endmodule
